// File: rtl/fft_out_split.sv
// Splits the packed {imag, real} FFT result stream into two independently
// backpressured AXI-Stream outputs. Optional frame-length checker: FFT_OUT_FRAME_CHECK_EN.
module fft_out_split #(
    parameter int DW        = 32,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 1024
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [2*DW-1:0] in_Tdata,
    input  logic            in_Tvalid,
    input  logic            in_Tlast,
    output logic            in_Tready,
    output logic [DW-1:0]   out1_Tdata,
    output logic            out1_Tvalid,
    output logic            out1_Tlast,
    input  logic            out1_Tready,
    output logic [DW-1:0]   out2_Tdata,
    output logic            out2_Tvalid,
    output logic            out2_Tlast,
    input  logic            out2_Tready,
    output logic            frame_err,
    output logic [7:0]      err_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef logic [DW:0] entry_t;

    entry_t        mem_q  [2][DEPTH];
    logic [AW-1:0] wptr_q [2];
    logic [AW-1:0] wptr_d [2];
    logic [AW-1:0] rptr_q [2];
    logic [AW-1:0] rptr_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];
    logic          full   [2];
    logic          empty  [2];
    logic          pop    [2];
    logic          out_ready [2];
    entry_t        wdata  [2];
    entry_t        head   [2];
    logic          push;

    always_comb begin
        out_ready[0] = out1_Tready;
        out_ready[1] = out2_Tready;
        wdata[0]     = {in_Tlast, in_Tdata[DW-1:0]};
        wdata[1]     = {in_Tlast, in_Tdata[2*DW-1:DW]};
        for (int n = 0; n < 2; n++) begin
            full[n]  = (cnt_q[n] == CW'(DEPTH));
            empty[n] = (cnt_q[n] == '0);
            head[n]  = mem_q[n][rptr_q[n]];
        end
    end

    // A full FIFO blocks the input even if it pops this cycle, so both sides stay aligned.
    assign in_Tready = aresetn && !full[0] && !full[1];
    assign push      = in_Tvalid && in_Tready;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            pop[n]    = !empty[n] && out_ready[n];
            wptr_d[n] = wptr_q[n];
            rptr_d[n] = rptr_q[n];
            cnt_d[n]  = cnt_q[n];
            if (push)   wptr_d[n] = wptr_q[n] + AW'(1);
            if (pop[n]) rptr_d[n] = rptr_q[n] + AW'(1);
            case ({push, pop[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + CW'(1);
                2'b01:   cnt_d[n] = cnt_q[n] - CW'(1);
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int n = 0; n < 2; n++) begin
                wptr_q[n] <= '0;
                rptr_q[n] <= '0;
                cnt_q[n]  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[n][i] <= '0;
                end
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                wptr_q[n] <= wptr_d[n];
                rptr_q[n] <= rptr_d[n];
                cnt_q[n]  <= cnt_d[n];
                if (push) begin
                    mem_q[n][wptr_q[n]] <= wdata[n];
                end
            end
        end
    end

    assign out1_Tvalid = !empty[0];
    assign out1_Tdata  = head[0][DW-1:0];
    assign out1_Tlast  = head[0][DW];
    assign out2_Tvalid = !empty[1];
    assign out2_Tdata  = head[1][DW-1:0];
    assign out2_Tlast  = head[1][DW];

`ifdef FFT_OUT_FRAME_CHECK_EN
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [BW-1:0] beat_q, beat_d;
    logic          err_q, err_d;
    logic [7:0]    errcnt_q, errcnt_d;
    logic          at_end;

    // An error is any accepted beat where Tlast disagrees with being the final slot.
    always_comb begin
        at_end   = (beat_q == BW'(FRAME_LEN - 1));
        beat_d   = beat_q;
        err_d    = 1'b0;
        errcnt_d = errcnt_q;
        if (push) begin
            err_d  = (in_Tlast != at_end);
            beat_d = (in_Tlast || at_end) ? '0 : beat_q + BW'(1);
        end
        if (err_d && errcnt_q != 8'hFF) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_q   <= '0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            beat_q   <= beat_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign frame_err = err_q;
    assign err_cnt   = errcnt_q;
`else
    assign frame_err = 1'b0;
    assign err_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_fft_out_split.sv
// Directed and scoreboard checks for fft_out_split (DEPTH=4, FRAME_LEN=16).
module tb_fft_out_split;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] in_Tdata = '0;
    logic        in_Tvalid = 1'b0;
    logic        in_Tlast = 1'b0;
    logic        in_Tready;
    logic [31:0] out1_Tdata, out2_Tdata;
    logic        out1_Tvalid, out1_Tlast, out1_Tready = 1'b0;
    logic        out2_Tvalid, out2_Tlast, out2_Tready = 1'b0;
    logic        frame_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int failures = 0;

    fft_out_split #(.DW(32), .DEPTH(4), .FRAME_LEN(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_Tdata(in_Tdata), .in_Tvalid(in_Tvalid), .in_Tlast(in_Tlast), .in_Tready(in_Tready),
        .out1_Tdata(out1_Tdata), .out1_Tvalid(out1_Tvalid), .out1_Tlast(out1_Tlast), .out1_Tready(out1_Tready),
        .out2_Tdata(out2_Tdata), .out2_Tvalid(out2_Tvalid), .out2_Tlast(out2_Tlast), .out2_Tready(out2_Tready),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        l;
        logic        r1, r2;
        logic        eRdy, eV1;
        logic [31:0] eD1;
        logic        eL1, eV2;
        logic [31:0] eD2;
        logic        eL2;
    } vec_t;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Waits for the next falling edge, drives one cycle of inputs, and settles.
    task automatic applyStimulus(input logic v, input logic [63:0] d, input logic l,
                                 input logic r1, input logic r2);
        @(negedge aclk);
        in_Tvalid   = v;
        in_Tdata    = d;
        in_Tlast    = l;
        out1_Tready = r1;
        out2_Tready = r2;
        #1;
    endtask

    task automatic pulseReset();
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    function automatic vec_t mk(input logic v, input int n, input logic l, input logic r1, input logic r2,
                                input logic eRdy, input logic eV1, input int eD1, input logic eL1,
                                input logic eV2, input int eD2, input logic eL2);
        vec_t t;
        t.v = v; t.d = {32'h200 + 32'(n), 32'(n)}; t.l = l; t.r1 = r1; t.r2 = r2;
        t.eRdy = eRdy; t.eV1 = eV1; t.eD1 = 32'(eD1); t.eL1 = eL1;
        t.eV2 = eV2; t.eD2 = 32'(eD2); t.eL2 = eL2;
        return t;
    endfunction

    vec_t vecs[12];
    logic [32:0] q1[$], q2[$];
    int pulses[$];

    initial begin
        vecs[0]  = mk(1, 0, 0, 1, 0,  1, 0, 0, 0,  0, 0,     0);
        vecs[1]  = mk(1, 1, 0, 1, 0,  1, 1, 0, 0,  1, 'h200, 0);
        vecs[2]  = mk(1, 2, 0, 1, 0,  1, 1, 1, 0,  1, 'h200, 0);
        vecs[3]  = mk(1, 3, 1, 1, 0,  1, 1, 2, 0,  1, 'h200, 0);
        vecs[4]  = mk(1, 4, 0, 1, 0,  0, 1, 3, 1,  1, 'h200, 0);
        vecs[5]  = mk(1, 4, 0, 1, 0,  0, 0, 0, 0,  1, 'h200, 0);
        vecs[6]  = mk(1, 4, 0, 1, 1,  0, 0, 0, 0,  1, 'h200, 0);
        vecs[7]  = mk(1, 4, 0, 1, 1,  1, 0, 0, 0,  1, 'h201, 0);
        vecs[8]  = mk(0, 0, 0, 1, 1,  1, 1, 4, 0,  1, 'h202, 0);
        vecs[9]  = mk(0, 0, 0, 1, 1,  1, 0, 0, 0,  1, 'h203, 1);
        vecs[10] = mk(0, 0, 0, 1, 1,  1, 0, 0, 0,  1, 'h204, 0);
        vecs[11] = mk(0, 0, 0, 1, 1,  1, 0, 0, 0,  0, 0,     0);

        // Reset state
        #2;
        checkOutput("rst_in_ready", in_Tready, 0);
        checkOutput("rst_v1", out1_Tvalid, 0);
        checkOutput("rst_v2", out2_Tvalid, 0);
        checkOutput("rst_d1", out1_Tdata, 0);
        checkOutput("rst_d2", out2_Tdata, 0);
        checkOutput("rst_err", frame_err, 0);
        checkOutput("rst_errcnt", err_cnt, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checkOutput("post_rst_ready", in_Tready, 1);

        // Eight beats, both consumers always ready
        for (int i = 0; i <= 9; i++) begin
            applyStimulus(i < 8, {32'h100 + 32'(i), 32'(i)}, i == 7, 1, 1);
            checkOutput("seq_ready", in_Tready, 1);
            if (i == 0 || i == 9) begin
                checkOutput("seq_v1_idle", out1_Tvalid, 0);
                checkOutput("seq_v2_idle", out2_Tvalid, 0);
            end else begin
                checkOutput("seq_v1", out1_Tvalid, 1);
                checkOutput("seq_d1", out1_Tdata, 32'(i - 1));
                checkOutput("seq_l1", out1_Tlast, (i - 1) == 7);
                checkOutput("seq_v2", out2_Tvalid, 1);
                checkOutput("seq_d2", out2_Tdata, 32'h100 + 32'(i - 1));
                checkOutput("seq_l2", out2_Tlast, (i - 1) == 7);
            end
        end

        // Backpressure on out2 only, table driven
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r1, vecs[i].r2);
            checkOutput($sformatf("bp%0d_ready", i), in_Tready, vecs[i].eRdy);
            checkOutput($sformatf("bp%0d_v1", i), out1_Tvalid, vecs[i].eV1);
            checkOutput($sformatf("bp%0d_v2", i), out2_Tvalid, vecs[i].eV2);
            if (vecs[i].eV1) begin
                checkOutput($sformatf("bp%0d_d1", i), out1_Tdata, vecs[i].eD1);
                checkOutput($sformatf("bp%0d_l1", i), out1_Tlast, vecs[i].eL1);
            end
            if (vecs[i].eV2) begin
                checkOutput($sformatf("bp%0d_d2", i), out2_Tdata, vecs[i].eD2);
                checkOutput($sformatf("bp%0d_l2", i), out2_Tlast, vecs[i].eL2);
            end
        end

        // Random traffic against a scoreboard
        begin
            int sent = 0;
            int cyc = 0;
            while (sent < 1000 && cyc < 20000) begin
                logic v, r1, r2, l, expRdy, p1, p2;
                logic [63:0] d;
                v  = ($urandom_range(0, 3) != 0);
                r1 = 1'($urandom_range(0, 1));
                r2 = 1'($urandom_range(0, 1));
                l  = ($urandom_range(0, 7) == 0);
                d  = {$urandom, $urandom};
                applyStimulus(v, d, l, r1, r2);
                expRdy = (q1.size() < 4) && (q2.size() < 4);
                checkOutput("rnd_ready", in_Tready, expRdy);
                checkOutput("rnd_v1", out1_Tvalid, q1.size() != 0);
                checkOutput("rnd_v2", out2_Tvalid, q2.size() != 0);
                if (q1.size() != 0) checkOutput("rnd_h1", {out1_Tlast, out1_Tdata}, q1[0]);
                if (q2.size() != 0) checkOutput("rnd_h2", {out2_Tlast, out2_Tdata}, q2[0]);
                p1 = r1 && q1.size() != 0;
                p2 = r2 && q2.size() != 0;
                if (p1) void'(q1.pop_front());
                if (p2) void'(q2.pop_front());
                if (v && expRdy) begin
                    q1.push_back({l, d[31:0]});
                    q2.push_back({l, d[63:32]});
                    sent++;
                end
                cyc++;
            end
            checkOutput("rnd_all_sent", sent, 1000);
            cyc = 0;
            while ((q1.size() != 0 || q2.size() != 0) && cyc < 20) begin
                applyStimulus(0, 0, 0, 1, 1);
                if (q1.size() != 0) checkOutput("drain_h1", {out1_Tvalid, out1_Tlast, out1_Tdata}, {1'b1, q1.pop_front()});
                if (q2.size() != 0) checkOutput("drain_h2", {out2_Tvalid, out2_Tlast, out2_Tdata}, {1'b1, q2.pop_front()});
                cyc++;
            end
            applyStimulus(0, 0, 0, 1, 1);
            checkOutput("drain_empty", {out1_Tvalid, out2_Tvalid}, 0);
        end

        // Reset with three beats buffered
        for (int i = 0; i < 3; i++) applyStimulus(1, {32'hA0 + 32'(i), 32'hB0 + 32'(i)}, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mid_buffered_v1", out1_Tvalid, 1);
        checkOutput("mid_buffered_d2", out2_Tdata, 32'hA0);
        aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_v1", out1_Tvalid, 0);
        checkOutput("mid_rst_v2", out2_Tvalid, 0);
        checkOutput("mid_rst_ready", in_Tready, 0);
        applyStimulus(0, 0, 0, 1, 1);
        aresetn = 1'b1;
        #1;
        checkOutput("mid_rel_ready", in_Tready, 1);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("mid_rel_v", {out1_Tvalid, out2_Tvalid}, 0);

        // Frame-length checker: frames of 16, 12 and 20 (no Tlast)
        pulseReset();
        begin
            int g = 0;
            int lens[3] = '{16, 12, 20};
            for (int f = 0; f < 3; f++) begin
                for (int b = 0; b < lens[f]; b++) begin
                    applyStimulus(1, 64'(g), (f < 2) && (b == lens[f] - 1), 1, 1);
                    if (frame_err) pulses.push_back(g - 1);
                    g++;
                end
            end
            for (int k = 0; k < 2; k++) begin
                applyStimulus(0, 0, 0, 1, 1);
                if (frame_err) pulses.push_back(g - 1);
                g++;
            end
        end
`ifdef FFT_OUT_FRAME_CHECK_EN
        checkOutput("fc_pulses", pulses.size(), 2);
        if (pulses.size() == 2) begin
            checkOutput("fc_pulse_short", pulses[0], 27);
            checkOutput("fc_pulse_long", pulses[1], 43);
        end
        checkOutput("fc_errcnt", err_cnt, 2);
`else
        checkOutput("fc_pulses", pulses.size(), 0);
        checkOutput("fc_errcnt", err_cnt, 0);
`endif

        // 300 short frames saturate the error counter
        pulseReset();
        for (int f = 0; f < 300; f++) begin
            applyStimulus(1, 0, 0, 1, 1);
            applyStimulus(1, 0, 1, 1, 1);
        end
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1, 1);
`ifdef FFT_OUT_FRAME_CHECK_EN
        checkOutput("sat_errcnt", err_cnt, 255);
`else
        checkOutput("sat_errcnt", err_cnt, 0);
`endif
        checkOutput("sat_err_idle", frame_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
